// File: rtl/l1_dcache_pkg.sv
// Shared definitions for the L1 dcache request/response adapters.
// Size encodings, adapter state encoding and byte-count helper.
package l1_dcache_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RESP = 2'd1,
        HOLD      = 2'd2
    } state_t;

    function automatic logic [3:0] bytes_of(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/l1_load_align.sv
// Load data aligner: shifts the raw 64-bit word down to the access
// offset and sign- or zero-extends it to the access size.
module l1_load_align
    import l1_dcache_pkg::*;
(
    input  logic [63:0] data,
    input  logic [2:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [63:0] result
);

    logic [63:0] shifted;

    // Shift to the byte offset, then extend from the access width.
    always_comb begin
        shifted = data >> {addr_lo, 3'b000};
        result  = shifted;
        unique case (size)
            SZ_B: result = {{56{shifted[7] & ~uns}}, shifted[7:0]};
            SZ_H: result = {{48{shifted[15] & ~uns}}, shifted[15:0]};
            SZ_W: result = {{32{shifted[31] & ~uns}}, shifted[31:0]};
            SZ_D: result = shifted;
        endcase
    end

endmodule

// File: rtl/l1_dcache_resp_adapter.sv
// Return path of the L1 dcache adapter: tracks one outstanding request,
// aligns load data, handles nack replay and timeouts, holds the response.
module l1_dcache_resp_adapter
    import l1_dcache_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_fire_i,
    input  logic        req_is_load_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [2:0]  req_addr_lo_i,
    output logic        req_rdy_o,
    input  logic        resp_valid_i,
    input  logic        resp_nack_i,
    input  logic [63:0] resp_data_i,
    output logic        rsp_valid_o,
    output logic        rsp_is_load_o,
    output logic [63:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic        rsp_misaligned_o,
    input  logic        core_ack_i,
    output logic        replay_o,
    output logic        spurious_o
);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic             m_is_load;
    logic             m_uns;
    logic [1:0]       m_size;
    logic [2:0]       m_addr;
    logic [63:0]      data_q;
    logic             err_q;
    logic             mis_q;
    logic             replay_q;
    logic             spur_q;
    logic [63:0]      aligned;
    logic             mis_req;
    logic             timeout;
    logic             fire;
    logic             hold;

    assign mis_req = ({1'b0, req_addr_lo_i} + bytes_of(req_size_i)) > 4'd8;
    assign timeout = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    assign fire    = (state == IDLE) && req_fire_i;
    assign hold    = state == HOLD;

    l1_load_align u_align (
        .data    (resp_data_i),
        .addr_lo (m_addr),
        .size    (m_size),
        .uns     (m_uns),
        .result  (aligned)
    );

    // Next-state decode; response beats nack, nack beats timeout.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (req_fire_i) state_nx = mis_req ? HOLD : WAIT_RESP;
            end
            WAIT_RESP: begin
                if (resp_valid_i)     state_nx = HOLD;
                else if (resp_nack_i) state_nx = IDLE;
                else if (timeout)     state_nx = HOLD;
            end
            HOLD: begin
                if (core_ack_i) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Saturating wait counter, cleared whenever a request issues.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (fire) begin
            cnt <= '0;
        end else if (state == WAIT_RESP && cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Request metadata; kept across a nack so the reissue matches.
    always_ff @(posedge clk) begin
        if (!rst) begin
            m_is_load <= 1'b0;
            m_uns     <= 1'b0;
            m_size    <= SZ_B;
            m_addr    <= 3'd0;
        end else if (fire) begin
            m_is_load <= req_is_load_i;
            m_uns     <= req_unsigned_i;
            m_size    <= req_size_i;
            m_addr    <= req_addr_lo_i;
        end
    end

    // Response payload, captured on the transition into HOLD.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q <= '0;
            err_q  <= 1'b0;
            mis_q  <= 1'b0;
        end else if (fire) begin
            data_q <= '0;
            err_q  <= mis_req;
            mis_q  <= mis_req;
        end else if (state == WAIT_RESP) begin
            if (resp_valid_i) begin
                data_q <= m_is_load ? aligned : 64'd0;
                err_q  <= 1'b0;
                mis_q  <= 1'b0;
            end else if (!resp_nack_i && timeout) begin
                data_q <= '0;
                err_q  <= 1'b1;
                mis_q  <= 1'b0;
            end
        end
    end

    // One-cycle replay and spurious-response pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            replay_q <= 1'b0;
            spur_q   <= 1'b0;
        end else begin
            replay_q <= (state == WAIT_RESP) && !resp_valid_i && resp_nack_i;
            spur_q   <= (state != WAIT_RESP) && (resp_valid_i || resp_nack_i);
        end
    end

    assign req_rdy_o        = state == IDLE;
    assign rsp_valid_o      = hold;
    assign rsp_is_load_o    = hold & m_is_load;
    assign rsp_data_o       = hold ? data_q : 64'd0;
    assign rsp_err_o        = hold & err_q;
    assign rsp_misaligned_o = hold & mis_q;
    assign replay_o         = replay_q;
    assign spurious_o       = spur_q;

endmodule

// File: tb/tb_l1_dcache_resp_adapter.sv
// Scoreboard bench for l1_dcache_resp_adapter: random and directed
// requests, expected responses queued by a behavioural model.
module tb_l1_dcache_resp_adapter;

    localparam int TO = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_fire_i = 1'b0;
    logic        req_is_load_i = 1'b0;
    logic [1:0]  req_size_i = 2'b00;
    logic        req_unsigned_i = 1'b0;
    logic [2:0]  req_addr_lo_i = 3'd0;
    logic        req_rdy_o;
    logic        resp_valid_i = 1'b0;
    logic        resp_nack_i = 1'b0;
    logic [63:0] resp_data_i = 64'd0;
    logic        rsp_valid_o;
    logic        rsp_is_load_o;
    logic [63:0] rsp_data_o;
    logic        rsp_err_o;
    logic        rsp_misaligned_o;
    logic        core_ack_i = 1'b0;
    logic        replay_o;
    logic        spurious_o;

    l1_dcache_resp_adapter #(.TIMEOUT_CYCLES(TO), .CNT_W(9)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_fire_i       (req_fire_i),
        .req_is_load_i    (req_is_load_i),
        .req_size_i       (req_size_i),
        .req_unsigned_i   (req_unsigned_i),
        .req_addr_lo_i    (req_addr_lo_i),
        .req_rdy_o        (req_rdy_o),
        .resp_valid_i     (resp_valid_i),
        .resp_nack_i      (resp_nack_i),
        .resp_data_i      (resp_data_i),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_is_load_o    (rsp_is_load_o),
        .rsp_data_o       (rsp_data_o),
        .rsp_err_o        (rsp_err_o),
        .rsp_misaligned_o (rsp_misaligned_o),
        .core_ack_i       (core_ack_i),
        .replay_o         (replay_o),
        .spurious_o       (spurious_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_load;
        bit          err;
        bit          mis;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    // Reference: take the bytes at the offset, extend from the top byte.
    function automatic logic [63:0] model_load(input logic [63:0] d,
            input int addr, input int size, input bit uns);
        int          nb;
        logic [63:0] v;
        logic [63:0] mask;
        nb   = 1 << size;
        v    = d >> (8 * addr);
        mask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF
                         : ((64'd1 << (8 * nb)) - 64'd1);
        v    = v & mask;
        if (!uns && nb < 8 && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    // Monitor: pop on the first cycle of each held response, then
    // require the outputs to stay frozen until the response drops.
    bit          seen = 0;
    logic [63:0] held_data;
    logic [2:0]  held_flags;
    always @(negedge clk) begin
        if (rsp_valid_o) begin
            if (!seen) begin
                seen = 1;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rsp: got data %h, none queued",
                             rsp_data_o);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_is_load", 64'(rsp_is_load_o), 64'(e.is_load));
                    check("rsp_err", 64'(rsp_err_o), 64'(e.err));
                    check("rsp_mis", 64'(rsp_misaligned_o), 64'(e.mis));
                    check("rsp_data", rsp_data_o, e.data);
                end
                held_data  = rsp_data_o;
                held_flags = {rsp_is_load_o, rsp_err_o, rsp_misaligned_o};
            end else begin
                check("hold_data", rsp_data_o, held_data);
                check("hold_flags",
                      64'({rsp_is_load_o, rsp_err_o, rsp_misaligned_o}),
                      64'(held_flags));
            end
        end else begin
            seen = 0;
        end
    end

    always @(posedge clk) begin
        if (rst && req_fire_i)
            assert (req_rdy_o) else $error("FAIL protocol: fire while busy");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic fire(input bit ld, input logic [1:0] sz, input bit uns,
                        input logic [2:0] a);
        req_fire_i     = 1'b1;
        req_is_load_i  = ld;
        req_size_i     = sz;
        req_unsigned_i = uns;
        req_addr_lo_i  = a;
        tick();
        req_fire_i     = 1'b0;
    endtask

    task automatic respond(input bit ld, input logic [1:0] sz,
                           input bit uns, input logic [2:0] a,
                           input logic [63:0] d);
        exp_t e;
        e.is_load = ld;
        e.err     = 1'b0;
        e.mis     = 1'b0;
        e.data    = ld ? model_load(d, int'(a), int'(sz), uns) : 64'd0;
        sb.push_back(e);
        resp_valid_i = 1'b1;
        resp_data_i  = d;
        tick();
        resp_valid_i = 1'b0;
        resp_data_i  = $urandom;
        check("rsp_latency", 64'(rsp_valid_o), 64'd1);
        check("no_spurious", 64'(spurious_o), 64'd0);
    endtask

    task automatic ack();
        repeat ($urandom_range(0, 3)) tick();
        core_ack_i = 1'b1;
        tick();
        core_ack_i = 1'b0;
        check("rdy_after_ack", 64'(req_rdy_o), 64'd1);
        check("valid_after_ack", 64'(rsp_valid_o), 64'd0);
    endtask

    // mode: 0 normal, 1 nack then replay, 2 timeout, 3 response on expiry
    task automatic run_txn(input bit ld, input logic [1:0] sz, input bit uns,
                           input logic [2:0] a, input logic [63:0] d,
                           input int mode, input bit use_lit,
                           input logic [63:0] lit);
        bit   mis;
        exp_t e;
        mis = (int'(a) + (1 << sz)) > 8;
        if (mis) begin
            e.is_load = ld;
            e.err     = 1'b1;
            e.mis     = 1'b1;
            e.data    = 64'd0;
            sb.push_back(e);
            fire(ld, sz, uns, a);
            check("mis_latency", 64'(rsp_valid_o), 64'd1);
            resp_valid_i = 1'b1;
            resp_data_i  = {$urandom, $urandom};
            tick();
            resp_valid_i = 1'b0;
            check("spurious_in_hold", 64'(spurious_o), 64'd1);
            ack();
            return;
        end
        fire(ld, sz, uns, a);
        if (mode == 1) begin
            repeat ($urandom_range(0, 3)) tick();
            resp_nack_i = 1'b1;
            tick();
            resp_nack_i = 1'b0;
            check("replay_pulse", 64'(replay_o), 64'd1);
            check("rdy_after_nack", 64'(req_rdy_o), 64'd1);
            fire(ld, sz, uns, a);
            check("replay_cleared", 64'(replay_o), 64'd0);
        end
        if (mode == 2 || mode == 3) begin
            repeat (TO - 1) tick();
            check("no_early_timeout", 64'(rsp_valid_o), 64'd0);
            if (mode == 2) begin
                e.is_load = ld;
                e.err     = 1'b1;
                e.mis     = 1'b0;
                e.data    = 64'd0;
                sb.push_back(e);
                tick();
                check("timeout_valid", 64'(rsp_valid_o), 64'd1);
                check("timeout_err", 64'(rsp_err_o), 64'd1);
            end else begin
                respond(ld, sz, uns, a, d);
                check("expiry_win_err", 64'(rsp_err_o), 64'd0);
            end
        end else begin
            repeat ($urandom_range(0, 4)) tick();
            check("no_early_rsp", 64'(rsp_valid_o), 64'd0);
            respond(ld, sz, uns, a, d);
        end
        if (use_lit) check("directed_data", rsp_data_o, lit);
        ack();
    endtask

    initial begin
        exp_t e;
        repeat (2) tick();
        check("rst_rdy", 64'(req_rdy_o), 64'd1);
        check("rst_valid", 64'(rsp_valid_o), 64'd0);
        check("rst_data", rsp_data_o, 64'd0);
        check("rst_flags", 64'({rsp_is_load_o, rsp_err_o, rsp_misaligned_o,
                                replay_o, spurious_o}), 64'd0);
        rst = 1'b1;
        tick();

        run_txn(1, 2'b10, 0, 3'd4, 64'h8000_0001_0000_0000, 0,
                1, 64'hFFFF_FFFF_8000_0001);
        run_txn(1, 2'b00, 1, 3'd7, 64'hAB00_0000_0000_0000, 0,
                1, 64'h0000_0000_0000_00AB);
        run_txn(1, 2'b00, 0, 3'd7, 64'hAB00_0000_0000_0000, 0,
                1, 64'hFFFF_FFFF_FFFF_FFAB);
        run_txn(1, 2'b01, 0, 3'd7, 64'd0, 0, 1, 64'd0);
        run_txn(0, 2'b10, 0, 3'd0, 64'h1234_5678_9ABC_DEF0, 1, 1, 64'd0);
        run_txn(1, 2'b11, 1, 3'd0, 64'h8123_4567_89AB_CDEF, 0,
                1, 64'h8123_4567_89AB_CDEF);
        run_txn(1, 2'b01, 1, 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 2, 1, 64'd0);
        run_txn(1, 2'b01, 0, 3'd2, 64'h0000_0000_8765_0000, 3,
                1, 64'hFFFF_FFFF_FFFF_8765);

        e.is_load = 1'b1;
        e.err     = 1'b0;
        e.mis     = 1'b0;
        e.data    = 64'h0000_0000_0000_0055;
        fire(1, 2'b00, 1, 3'd1);
        respond(1, 2'b00, 1, 3'd1, 64'h0000_0000_0000_5500);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("rst_hold_valid", 64'(rsp_valid_o), 64'd0);
        check("rst_hold_rdy", 64'(req_rdy_o), 64'd1);
        check("rst_hold_replay", 64'(replay_o), 64'd0);
        check("rst_hold_data", rsp_data_o, 64'd0);
        tick();

        for (int i = 0; i < 150; i++) begin
            run_txn($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                    $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
                    {$urandom, $urandom},
                    ($urandom_range(0, 3) == 0) ? 1 : 0, 0, 64'd0);
        end

        repeat (3) tick();
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/l1_dcache_resp_adapter.md
Name: l1_dcache_resp_adapter

Overview:
Return-path companion to the L1 dcache request adapter. It captures per-request metadata when a load or store request is issued to the dcache, then waits for the dcache response. For loads it aligns and sign/zero-extends the returned 64-bit word. It presents one registered response to the core and holds it until the core acknowledges. One request is outstanding at a time, and the block adds nack replay and timeout handling.

Parameters:
TIMEOUT_CYCLES, 256, cycles in WAIT_RESP before an error response is forced
CNT_W, 9, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
req_fire_i  in  1  request issued to dcache this cycle (load or store)
req_is_load_i  in  1  1 = load, 0 = store
req_size_i  in  2  00 B, 01 H, 10 W, 11 D
req_unsigned_i  in  1  zero-extend load result
req_addr_lo_i  in  3  vaddr[2:0] of the request
req_rdy_o  out  1  adapter idle; request may fire
resp_valid_i  in  1  dcache response valid
resp_nack_i  in  1  dcache rejected the request; replay required
resp_data_i  in  64  raw dcache word
rsp_valid_o  out  1  response held for the core
rsp_is_load_o  out  1  held response is a load
rsp_data_o  out  64  aligned/extended load data; 0 for stores
rsp_err_o  out  1  timeout or misaligned
rsp_misaligned_o  out  1  access crossed the 8-byte word
core_ack_i  in  1  core consumes the held response
replay_o  out  1  one-cycle pulse: reissue the request
spurious_o  out  1  one-cycle pulse: resp_valid_i or resp_nack_i seen outside WAIT_RESP

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE, counter=0, all metadata cleared.
  - All outputs 0, except req_rdy_o=1.
  - Reset mid-operation discards any held or pending response; no replay_o pulse.
- States: IDLE, WAIT_RESP, HOLD.
- IDLE: req_rdy_o=1.
  - req_fire_i latches is_load, size, unsigned, addr_lo.
  - If addr_lo + 2^size > 8 (misaligned): go to HOLD with rsp_err_o=1, rsp_misaligned_o=1, rsp_data_o=0. The dcache response for that request is ignored.
  - Otherwise: go to WAIT_RESP and clear the counter.
  - req_fire_i outside IDLE is ignored (protocol violation; assertion in bench).
- WAIT_RESP: counter increments each cycle. Priority in the same cycle is resp_valid_i > resp_nack_i > timeout.
  - resp_valid_i: go to HOLD next cycle.
    - Load: rsp_data_o = extend(resp_data_i >> (8*addr_lo), size, unsigned).
    - Store: rsp_data_o=0.
  - resp_nack_i: replay_o=1 for one cycle; return to IDLE with metadata retained for the reissue.
  - counter == TIMEOUT_CYCLES-1 with no response: go to HOLD with rsp_err_o=1, data 0.
- HOLD: rsp_valid_o=1. All rsp_* outputs are stable until core_ack_i.
  - core_ack_i: go to IDLE next cycle.
  - resp_valid_i in HOLD raises spurious_o and does not alter the held data.
- Latency: resp_valid_i at edge N gives rsp_valid_o high after edge N+1 (registered). Minimum request-to-request spacing is 3 cycles.
- Extension rules: the result takes the low 8/16/32/64 bits of the shifted word.
  - Bit 7/15/31 is replicated unless req_unsigned_i=1.
  - Size D ignores the unsigned flag.
- Counter saturates and never wraps; it is cleared on entry to WAIT_RESP.

Decomposition:
- Shared package l1_dcache_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D
  - the state encoding
  - the function bytes_of(size)
- One combinational sub-module, l1_load_align: inputs data, addr_lo, size, unsigned; output 64-bit result. It is reused by any future non-cacheable load path.

Test Plan:
- LW signed, addr_lo=4, resp_data=0x8000_0001_0000_0000 -> rsp_data_o=0xFFFF_FFFF_8000_0001, rsp_valid_o one cycle after resp_valid_i, held until core_ack_i.
- LBU, addr_lo=7, resp_data=0xAB00_0000_0000_0000 -> rsp_data_o=0x0000_0000_0000_00AB. LB at the same address -> 0xFFFF_FFFF_FFFF_FFAB.
- LH at addr_lo=7 -> no wait for the dcache; rsp_err_o=1, rsp_misaligned_o=1, rsp_data_o=0 one cycle after fire. A later resp_valid_i raises spurious_o.
- Store, resp_nack_i in WAIT_RESP -> replay_o pulse, req_rdy_o=1 next cycle. Refire, then resp_valid_i -> rsp_valid_o=1, rsp_is_load_o=0, data 0.
- No response for TIMEOUT_CYCLES -> rsp_err_o=1 exactly at cycle TIMEOUT_CYCLES after entry. A resp_valid_i arriving on the expiry cycle wins instead (no error).
- rst=0 asserted during HOLD with core_ack_i low -> next cycle rsp_valid_o=0, req_rdy_o=1, no replay_o.
